mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
// - MEM/WB pipeline register plus writeback-side load alignment; directly drives the register file write port (waddr/wdata/we).
// - Captures MEM results and load attributes, then merges synchronous data-RAM read data (valid one cycle after capture) into the final 32-bit writeback value.
// - Honours stall/flush from the pipeline controller; preserves RAM data across WB stalls.
// PARAMETERS
// - DATA_W   32  datapath width (only 32 supported)
// - RADDR_W  5   register address width
// PORTS
// - clk           in   1        clock, rising edge
// - rst           in   1        asynchronous, active-low reset (0 = reset)
// - stall_mem     in   1        MEM stage stalled this cycle
// - stall_wb      in   1        WB stage stalled this cycle
// - flush         in   1        exception flush; kills the instruction entering WB
// - mem_wd        in   RADDR_W  destination register from MEM
// - mem_wreg      in   1        write enable from MEM
// - mem_wdata     in   DATA_W   ALU/move result from MEM
// - mem_load_op   in   3        000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, 110 LWL, 111 LWR
// - mem_addr_lo   in   2        byte offset of load address
// - mem_rt_data   in   DATA_W   old rt value, used for the LWL/LWR merge
// - dram_rdata    in   DATA_W   sync RAM read data, valid the cycle after capture
// - wb_wd         out  RADDR_W  regfile waddr
// - wb_wreg       out  1        regfile we
// - wb_wdata      out  DATA_W   regfile wdata (combinational from WB state)
// BEHAVIOUR
// - Reset (rst=0, async): wb_wd=0, wb_wreg=0, all internal regs=0, so wb_wdata=0; hold_vld=0.
// - Register update priority at each posedge:
//   - flush: bubble (wd=0, wreg=0, op=000, data=0).
//   - else stall_mem && !stall_wb: bubble.
//   - else !stall_mem: load all mem_* fields.
//   - else: hold.
// - stall_mem=0 with stall_wb=1 is illegal; the controller never drives it. The bench must assert this.
// - Latency: one cycle from MEM inputs to wb_* outputs. Load data is combined in the WB cycle.
// - hold_vld / rdata_hold:
//   - On a cycle with stall_wb=1, WB op!=000 and hold_vld=0: capture dram_rdata into rdata_hold and set hold_vld.
//   - hold_vld clears on any WB register update (new instruction or bubble).
//   - Load source = hold_vld ? rdata_hold : dram_rdata.
// - wb_wdata by op (big-endian, offset 0 = bits[31:24]; d = load source, rt = latched rt):
//   - 000: latched ALU data.
//   - LB/LBU: selected byte, sign/zero extended.
//   - LH/LHU: offset[1]=0 gives d[31:16], else d[15:0]; sign/zero extended.
//   - LW: d.
//   - LWL, offset 0..3: d | {d[23:0],rt[7:0]} | {d[15:0],rt[15:0]} | {d[7:0],rt[23:0]}.
//   - LWR, offset 0..3: {rt[31:8],d[31:24]} | {rt[31:16],d[31:16]} | {rt[31:24],d[31:8]} | d.
// - Misalignment is not checked here (MEM raises AdEL). For LH the offset LSB is ignored; for LW both bits are ignored.
// - wb_wreg is passed through unmodified for wd=0; the register file discards r0 writes.
// - A flush coinciding with stall_wb still produces a bubble and clears hold_vld.
// CONFIGURATION
// - MEM_WB_LLBIT_EN defined:
//   - Extra ports: mem_llbit_we (in, 1), mem_llbit_val (in, 1), llbit_o (out, 1).
//   - The pipeline carries mem_llbit_we/mem_llbit_val into WB.
//   - The LLbit register updates at the posedge where WB llbit_we=1 and stall_wb=0.
//   - flush clears LLbit (ERET/exception) with priority over the write.
//   - llbit_o forwards the WB pending value when WB llbit_we=1, else the register.
//   - Reset clears LLbit to 0.
// - Not defined: these ports and all LL logic are absent; behaviour is otherwise identical.
// TESTING
// - LBU, off=2, dram=0x11223344 -> wb_wdata=0x00000033, wb_wreg=1, wb_wd=mem_wd after 1 cycle.
// - LB off=0, dram=0x80FF0000 -> 0xFFFFFF80. LH off=2, dram=0x0000F00D -> 0xFFFFF00D.
// - LWL off=1, rt=0xAABBCCDD, dram=0x11223344 -> 0x223344DD. LWR off=1, same inputs -> 0xAABB1122.
// - stall_mem=1, stall_wb=0 for 1 cycle -> next cycle wb_wreg=0, wb_wd=0. Then release -> held instruction appears.
// - LW in WB, stall_wb=1 for 3 cycles while dram_rdata changes 0x12345678 -> 0xDEADBEEF -> wb_wdata stays 0x12345678 throughout.
// - rst=0 asserted mid-stall, between clock edges -> outputs 0 immediately. With LLBIT_EN: LL then flush -> llbit_o=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback-side load alignment driving the regfile write port.
// Latency: 1 cycle from mem_* capture to wb_*; wb_wdata is combinational from WB state and RAM data.
// Backpressure: stall_wb holds WB and preserves the RAM word; stall_mem alone inserts a bubble.
//
// Ports:
//   clk, rst (async, active-low)   clock and reset
//   stall_mem, stall_wb, flush     pipeline control from the hazard/exception unit
//   mem_*                          MEM-stage result, load attributes and old rt value
//   dram_rdata                     synchronous data-RAM read data, valid the cycle after capture
//   wb_wd / wb_wreg / wb_wdata     register-file write address, enable and data
//
// Optional feature (define MEM_WB_LLBIT_EN): carries LL/SC link-bit writes into WB and keeps
// the LLbit register, exported on llbit_o. Extra ports: mem_llbit_we, mem_llbit_val, llbit_o.
// With the macro undefined these ports and all LLbit logic are absent.

module mem_wb_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_mem,
    input  logic               stall_wb,
    input  logic               flush,
    input  logic [RADDR_W-1:0] mem_wd,
    input  logic               mem_wreg,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic [2:0]         mem_load_op,
    input  logic [1:0]         mem_addr_lo,
    input  logic [DATA_W-1:0]  mem_rt_data,
    input  logic [DATA_W-1:0]  dram_rdata,
`ifdef MEM_WB_LLBIT_EN
    input  logic               mem_llbit_we,
    input  logic               mem_llbit_val,
    output logic               llbit_o,
`endif
    output logic [RADDR_W-1:0] wb_wd,
    output logic               wb_wreg,
    output logic [DATA_W-1:0]  wb_wdata
);

    typedef enum logic [2:0] {
        LD_NONE = 3'b000,
        LD_LB   = 3'b001,
        LD_LBU  = 3'b010,
        LD_LH   = 3'b011,
        LD_LHU  = 3'b100,
        LD_LW   = 3'b101,
        LD_LWL  = 3'b110,
        LD_LWR  = 3'b111
    } load_op_e;

    // WB-stage state
    load_op_e          wb_op;
    logic [DATA_W-1:0] wb_data;
    logic [1:0]        wb_off;
    logic [DATA_W-1:0] wb_rt;

    // RAM word saved while WB is stalled; the RAM output moves on after its one valid cycle.
    logic              hold_vld;
    logic [DATA_W-1:0] rdata_hold;

    // Update decode. A bubble wins over a load; with neither, both stalls are high and WB holds.
    logic do_bubble;
    logic do_load;
    logic wb_update;

    assign do_bubble = flush | (stall_mem & ~stall_wb);
    assign do_load   = ~do_bubble & ~stall_mem;
    assign wb_update = do_bubble | do_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_wd   <= '0;
            wb_wreg <= 1'b0;
            wb_op   <= LD_NONE;
            wb_data <= '0;
            wb_off  <= 2'b00;
            wb_rt   <= '0;
        end else if (do_bubble) begin
            wb_wd   <= '0;
            wb_wreg <= 1'b0;
            wb_op   <= LD_NONE;
            wb_data <= '0;
            wb_off  <= 2'b00;
            wb_rt   <= '0;
        end else if (do_load) begin
            wb_wd   <= mem_wd;
            wb_wreg <= mem_wreg;
            wb_op   <= load_op_e'(mem_load_op);
            wb_data <= mem_wdata;
            wb_off  <= mem_addr_lo;
            wb_rt   <= mem_rt_data;
        end
    end

    // Only the first stalled cycle of a load sees the RAM word (hold_vld is still clear then),
    // so that is the one snapshot taken; later stall cycles keep it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_vld   <= 1'b0;
            rdata_hold <= '0;
        end else if (wb_update) begin
            hold_vld <= 1'b0;
        end else if (stall_wb && (wb_op != LD_NONE) && !hold_vld) begin
            hold_vld   <= 1'b1;
            rdata_hold <= dram_rdata;
        end
    end

    // Load alignment, big-endian: byte offset 0 is bits [31:24].
    logic [DATA_W-1:0] ld_src;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    assign ld_src = hold_vld ? rdata_hold : dram_rdata;

    always_comb begin
        ld_byte = ld_src[31:24];
        case (wb_off)
            2'd0:    ld_byte = ld_src[31:24];
            2'd1:    ld_byte = ld_src[23:16];
            2'd2:    ld_byte = ld_src[15:8];
            default: ld_byte = ld_src[7:0];
        endcase
    end

    // Halfword ignores the offset LSB; misalignment is trapped upstream.
    assign ld_half = wb_off[1] ? ld_src[15:0] : ld_src[31:16];

    always_comb begin
        wb_wdata = wb_data;
        case (wb_op)
            LD_NONE: wb_wdata = wb_data;
            LD_LB:   wb_wdata = {{24{ld_byte[7]}}, ld_byte};
            LD_LBU:  wb_wdata = {24'h000000, ld_byte};
            LD_LH:   wb_wdata = {{16{ld_half[15]}}, ld_half};
            LD_LHU:  wb_wdata = {16'h0000, ld_half};
            LD_LW:   wb_wdata = ld_src;
            // LWL fills the register from the MSB side, keeping low bytes of rt.
            LD_LWL: begin
                case (wb_off)
                    2'd0:    wb_wdata = ld_src;
                    2'd1:    wb_wdata = {ld_src[23:0], wb_rt[7:0]};
                    2'd2:    wb_wdata = {ld_src[15:0], wb_rt[15:0]};
                    default: wb_wdata = {ld_src[7:0],  wb_rt[23:0]};
                endcase
            end
            // LWR fills the register from the LSB side, keeping high bytes of rt.
            LD_LWR: begin
                case (wb_off)
                    2'd0:    wb_wdata = {wb_rt[31:8],  ld_src[31:24]};
                    2'd1:    wb_wdata = {wb_rt[31:16], ld_src[31:16]};
                    2'd2:    wb_wdata = {wb_rt[31:24], ld_src[31:8]};
                    default: wb_wdata = ld_src;
                endcase
            end
            default: wb_wdata = wb_data;
        endcase
    end

`ifdef MEM_WB_LLBIT_EN
    logic wb_llbit_we;
    logic wb_llbit_val;
    logic llbit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_llbit_we  <= 1'b0;
            wb_llbit_val <= 1'b0;
        end else if (do_bubble) begin
            wb_llbit_we  <= 1'b0;
            wb_llbit_val <= 1'b0;
        end else if (do_load) begin
            wb_llbit_we  <= mem_llbit_we;
            wb_llbit_val <= mem_llbit_val;
        end
    end

    // ERET/exception kills the link even if an LL/SC is committing in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llbit <= 1'b0;
        end else if (flush) begin
            llbit <= 1'b0;
        end else if (wb_llbit_we && !stall_wb) begin
            llbit <= wb_llbit_val;
        end
    end

    // Forward the in-flight value so an SC right behind an LL sees the new link.
    assign llbit_o = wb_llbit_we ? wb_llbit_val : llbit;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    localparam logic [2:0] OP_NONE = 3'd0, OP_LB = 3'd1, OP_LBU = 3'd2, OP_LH = 3'd3,
                           OP_LHU = 3'd4, OP_LW = 3'd5, OP_LWL = 3'd6, OP_LWR = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_mem, stall_wb, flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_load_op;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_rt_data;
    logic [31:0] dram_rdata;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
`ifdef MEM_WB_LLBIT_EN
    logic        mem_llbit_we, mem_llbit_val, llbit_o;
`endif

    mem_wb_stage #(.DATA_W(32), .RADDR_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_mem   (stall_mem),
        .stall_wb    (stall_wb),
        .flush       (flush),
        .mem_wd      (mem_wd),
        .mem_wreg    (mem_wreg),
        .mem_wdata   (mem_wdata),
        .mem_load_op (mem_load_op),
        .mem_addr_lo (mem_addr_lo),
        .mem_rt_data (mem_rt_data),
        .dram_rdata  (dram_rdata),
`ifdef MEM_WB_LLBIT_EN
        .mem_llbit_we  (mem_llbit_we),
        .mem_llbit_val (mem_llbit_val),
        .llbit_o       (llbit_o),
`endif
        .wb_wd       (wb_wd),
        .wb_wreg     (wb_wreg),
        .wb_wdata    (wb_wdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        llbit;
    } exp_t;

    exp_t sbq[$];

    // Reference model: the instruction sitting in WB, plus the RAM word it was served.
    logic [4:0]  m_wd = '0;
    logic        m_wreg = 1'b0;
    logic [2:0]  m_op = '0;
    logic [31:0] m_data = '0;
    logic [1:0]  m_off = '0;
    logic [31:0] m_rt = '0;
    logic [31:0] m_word = '0;
    logic        m_first = 1'b0;
    logic        m_llwe = 1'b0, m_llval = 1'b0, m_ll = 1'b0;
    logic        ll_we_n = 1'b0, ll_val_n = 1'b0;

    function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] alu, input logic [31:0] rt,
                                              input logic [31:0] d);
        logic [31:0] b;
        logic [63:0] mask;
        case (op)
            OP_LB, OP_LBU: begin
                b = (d >> (8 * (3 - off))) & 32'hFF;
                if (op == OP_LB && b[7]) b = b | 32'hFFFFFF00;
                return b;
            end
            OP_LH, OP_LHU: begin
                b = (d >> (16 * (1 - off[1]))) & 32'hFFFF;
                if (op == OP_LH && b[15]) b = b | 32'hFFFF0000;
                return b;
            end
            OP_LW: return d;
            OP_LWL: begin
                mask = (64'd1 << (8 * off)) - 64'd1;
                return (d << (8 * off)) | (rt & mask[31:0]);
            end
            OP_LWR: begin
                mask = (64'd1 << (8 * (off + 1))) - 64'd1;
                return (d >> (8 * (3 - off))) | (rt & ~mask[31:0]);
            end
            default: return alu;
        endcase
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pipeline register rules applied to whatever the bench drove for this edge.
    task automatic model_advance();
        if (flush) m_ll = 1'b0;
        else if (m_llwe && !stall_wb) m_ll = m_llval;
        if (flush || (stall_mem && !stall_wb)) begin
            m_wd = '0; m_wreg = 1'b0; m_op = OP_NONE; m_data = '0; m_off = '0; m_rt = '0;
            m_first = 1'b0; m_llwe = 1'b0; m_llval = 1'b0;
        end else if (!stall_mem) begin
            m_wd = mem_wd; m_wreg = mem_wreg; m_op = mem_load_op; m_data = mem_wdata;
            m_off = mem_addr_lo; m_rt = mem_rt_data; m_first = 1'b1;
`ifdef MEM_WB_LLBIT_EN
            m_llwe = mem_llbit_we; m_llval = mem_llbit_val;
`endif
        end
    endtask

    task automatic model_reset();
        m_wd = '0; m_wreg = 1'b0; m_op = OP_NONE; m_data = '0; m_off = '0; m_rt = '0;
        m_word = '0; m_first = 1'b0; m_llwe = 1'b0; m_llval = 1'b0; m_ll = 1'b0;
    endtask

    // One cycle: advance model at the edge, drive the next inputs plus this cycle's RAM word,
    // and push the expected WB output for this cycle.
    task automatic step(input logic sm, input logic sw, input logic fl,
                        input logic [4:0] wd, input logic wr, input logic [31:0] wdat,
                        input logic [2:0] op, input logic [1:0] off, input logic [31:0] rt,
                        input logic [31:0] dram, input logic use_lit, input logic [31:0] lit);
        exp_t e;
        @(posedge clk);
        model_advance();
        #1;
        stall_mem = sm; stall_wb = sw; flush = fl;
        mem_wd = wd; mem_wreg = wr; mem_wdata = wdat; mem_load_op = op;
        mem_addr_lo = off; mem_rt_data = rt; dram_rdata = dram;
`ifdef MEM_WB_LLBIT_EN
        mem_llbit_we = ll_we_n; mem_llbit_val = ll_val_n;
`endif
        // The RAM word belongs to the first WB cycle of a load; later cycles may see garbage.
        if (m_op != OP_NONE && m_first) begin
            m_word = dram;
            m_first = 1'b0;
        end
        e.wd = m_wd;
        e.wreg = m_wreg;
        e.wdata = use_lit ? lit : ref_wdata(m_op, m_off, m_data, m_rt, m_word);
        e.llbit = m_llwe ? m_llval : m_ll;
        sbq.push_back(e);
    endtask

    // Monitor: compare the DUT against the oldest expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if ({wb_wd, wb_wreg, wb_wdata} !== {e.wd, e.wreg, e.wdata}) begin
                    errors++;
                    $display("FAIL wb_out @%0t: got wd=%0d we=%0b data=0x%08h expected wd=%0d we=%0b data=0x%08h",
                             $time, wb_wd, wb_wreg, wb_wdata, e.wd, e.wreg, e.wdata);
                end
`ifdef MEM_WB_LLBIT_EN
                checks++;
                if (llbit_o !== e.llbit) begin
                    errors++;
                    $display("FAIL llbit_o @%0t: got %0b expected %0b", $time, llbit_o, e.llbit);
                end
`endif
            end
        end
    end

    // The controller never lets MEM advance into a stalled WB.
    always @(posedge clk) begin
        if (rst) begin
            assert (stall_mem || !stall_wb)
            else begin
                errors++;
                $display("FAIL illegal_stall @%0t: stall_mem=0 with stall_wb=1", $time);
            end
        end
    end

    initial begin
        int r;
        rst = 1'b0;
        stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0;
        mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0; mem_load_op = '0;
        mem_addr_lo = '0; mem_rt_data = '0; dram_rdata = 32'hFFFFFFFF;
`ifdef MEM_WB_LLBIT_EN
        mem_llbit_we = 1'b0; mem_llbit_val = 1'b0;
`endif
        #2;
        check32("reset_wd", {27'd0, wb_wd}, 32'd0);
        check32("reset_wreg", {31'd0, wb_wreg}, 32'd0);
        check32("reset_wdata", wb_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Alignment vectors; the literal is the required wdata for the instruction now in WB.
        step(0, 0, 0,  5, 1, 32'h0, OP_LBU, 2, 32'h0,         32'h0,        0, 32'h0);
        step(0, 0, 0,  6, 1, 32'h0, OP_LB,  0, 32'h0,         32'h11223344, 1, 32'h00000033);
        step(0, 0, 0,  7, 1, 32'h0, OP_LH,  2, 32'h0,         32'h80FF0000, 1, 32'hFFFFFF80);
        step(0, 0, 0,  8, 1, 32'h0, OP_LWL, 1, 32'hAABBCCDD,  32'h0000F00D, 1, 32'hFFFFF00D);
        step(0, 0, 0,  9, 1, 32'h0, OP_LWR, 1, 32'hAABBCCDD,  32'h11223344, 1, 32'h223344DD);
        step(0, 0, 0, 10, 1, 32'h0, OP_LW,  3, 32'h0,         32'h11223344, 1, 32'hAABB1122);
        // LW held in WB for three stalled cycles while the RAM output changes.
        step(1, 1, 0, 11, 1, 32'hCAFEF00D, OP_NONE, 0, 32'h0, 32'h12345678, 1, 32'h12345678);
        step(1, 1, 0, 11, 1, 32'hCAFEF00D, OP_NONE, 0, 32'h0, 32'hDEADBEEF, 1, 32'h12345678);
        step(1, 1, 0, 11, 1, 32'hCAFEF00D, OP_NONE, 0, 32'h0, 32'h0BADF00D, 1, 32'h12345678);
        // MEM-only stall: bubble next, then the held ALU instruction.
        step(1, 0, 0, 11, 1, 32'hCAFEF00D, OP_NONE, 0, 32'h0, 32'hFFFFFFFF, 1, 32'h12345678);
        step(0, 0, 0, 11, 1, 32'hCAFEF00D, OP_NONE, 0, 32'h0, 32'h0,        1, 32'h0);
        step(0, 0, 0, 12, 1, 32'h0, OP_LW, 0, 32'h0,          32'h0,        1, 32'hCAFEF00D);
        step(1, 1, 0, 12, 1, 32'h0, OP_LW, 0, 32'h0,          32'h01020304, 1, 32'h01020304);

        // Asynchronous reset between edges during a stall.
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check32("midrst_wd", {27'd0, wb_wd}, 32'd0);
        check32("midrst_wreg", {31'd0, wb_wreg}, 32'd0);
        check32("midrst_wdata", wb_wdata, 32'd0);
        model_reset();
        #1 rst = 1'b1;

        // Flush together with stall_wb still bubbles.
        step(0, 0, 0, 13, 1, 32'h0, OP_LH, 0, 32'h0, 32'h55555555, 1, 32'h0);
        step(1, 1, 1, 14, 1, 32'h0, OP_LW, 0, 32'h0, 32'h80010000, 1, 32'hFFFF8001);
        step(0, 0, 0, 15, 1, 32'h0, OP_NONE, 0, 32'h0, 32'h0, 1, 32'h0);

`ifdef MEM_WB_LLBIT_EN
        ll_we_n = 1'b1; ll_val_n = 1'b1;
        step(0, 0, 0, 16, 1, 32'h0, OP_LW, 0, 32'h0, 32'h0, 0, 32'h0);
        ll_we_n = 1'b0; ll_val_n = 1'b0;
        step(0, 0, 1, 17, 1, 32'h0, OP_NONE, 0, 32'h0, 32'h0, 0, 32'h0);
        step(0, 0, 0, 18, 1, 32'h0, OP_NONE, 0, 32'h0, 32'h0, 0, 32'h0);
        #2 check32("ll_after_flush", {31'd0, llbit_o}, 32'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            logic sm, sw;
            r = $urandom_range(9);
            sm = (r >= 6);
            sw = (r >= 8);
`ifdef MEM_WB_LLBIT_EN
            ll_we_n = ($urandom_range(3) == 0);
            ll_val_n = 1'($urandom_range(1));
`endif
            step(sm, sw, ($urandom_range(15) == 0),
                 5'($urandom), 1'($urandom), $urandom, 3'($urandom), 2'($urandom),
                 $urandom, $urandom, 0, 32'h0);
        end

        @(negedge clk);
        #1;
        check32("sb_drained", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
